// File: rtl/trng_postproc.sv
// TRNG post-processor: warm-up, repetition-count health test, byte packer and 2-entry output FIFO.
// Define VON_NEUMANN_EN to compile in the Von Neumann debiaser on the RUN bit stream.
module trng_postproc #(
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter int unsigned RCT_CUTOFF    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       alarm_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       alarm,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, WARMUP, RUN, ALARM} state_t;

  localparam logic [15:0] WU_LAST = 16'(WARMUP_CYCLES - 1);
  localparam logic [7:0]  CUT     = 8'(RCT_CUTOFF);

  state_t      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  rl_q, rl_d, rl_next;
  logic        prev_q, fresh_q, fresh_d;
  logic [7:0]  pack_q, pack_d, push_byte;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept, abit, push, flush, pop, wr_ok, ovf_q, ovf_d;
  logic [1:0]  fcnt_q;
  logic        rptr_q, wptr_q;
  logic [7:0]  mem_q [2];
`ifdef VON_NEUMANN_EN
  logic        pair_have_q, pair_have_d, pair_bit_q, pair_bit_d;
`endif

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rl_d      = rl_q;
    fresh_d   = fresh_q;
    pack_d    = pack_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    abit      = bit_in;
    flush     = 1'b0;
    push      = 1'b0;
    push_byte = pack_q;
`ifdef VON_NEUMANN_EN
    pair_have_d = pair_have_q;
    pair_bit_d  = pair_bit_q;
`endif
    rl_next = (fresh_q || bit_in != prev_q) ? 8'd1 : rl_q + 8'd1;
    case (state_q)
      IDLE:  if (enable)    begin state_d = WARMUP; wcnt_d = '0; fresh_d = 1'b1; end
      ALARM: if (alarm_clr) begin state_d = WARMUP; wcnt_d = '0; fresh_d = 1'b1; end
      default: begin
        rl_d    = rl_next;
        fresh_d = 1'b0;
        // health test outranks the enable drop
        if (rl_next == CUT || !enable) begin
          state_d = (rl_next == CUT) ? ALARM : IDLE;
          flush   = (rl_next == CUT);
          pack_d  = '0;
          cnt_d   = '0;
`ifdef VON_NEUMANN_EN
          pair_have_d = 1'b0;
          pair_bit_d  = 1'b0;
`endif
        end else if (state_q == WARMUP) begin
          if (wcnt_q == WU_LAST) state_d = RUN;
          else                   wcnt_d  = wcnt_q + 16'd1;
        end else begin
`ifdef VON_NEUMANN_EN
          pair_have_d = ~pair_have_q;
          if (!pair_have_q) pair_bit_d = bit_in;
          else if (pair_bit_q != bit_in) begin
            accept = 1'b1;
            abit   = pair_bit_q;
          end
`else
          accept = 1'b1;
`endif
        end
      end
    endcase
    if (accept) begin
      pack_d[cnt_q] = abit;
      cnt_d         = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        push      = 1'b1;
        push_byte = pack_d;
        pack_d    = '0;
      end
    end
  end

  assign data_valid = (fcnt_q != 2'd0);
  assign pop        = data_valid & data_ready;
  // a full FIFO still accepts when the head leaves on the same edge
  assign wr_ok      = push & ((fcnt_q != 2'd2) | pop);
  assign ovf_d      = (ovf_q & ~alarm_clr) | (push & ~wr_ok);
  assign data_out   = data_valid ? mem_q[rptr_q] : 8'h00;
  assign alarm      = (state_q == ALARM);
  assign overflow   = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rl_q    <= '0;
      prev_q  <= 1'b0;
      fresh_q <= 1'b1;
      pack_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef VON_NEUMANN_EN
      pair_have_q <= 1'b0;
      pair_bit_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rl_q    <= rl_d;
      prev_q  <= bit_in;
      fresh_q <= fresh_d;
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef VON_NEUMANN_EN
      pair_have_q <= pair_have_d;
      pair_bit_q  <= pair_bit_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q   <= '0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush) begin
      fcnt_q <= '0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
    end else begin
      if (pop) rptr_q <= ~rptr_q;
      if (wr_ok) begin
        mem_q[wptr_q] <= push_byte;
        wptr_q        <= ~wptr_q;
      end
      case ({wr_ok, pop})
        2'b10:   fcnt_q <= fcnt_q + 2'd1;
        2'b01:   fcnt_q <= fcnt_q - 2'd1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end
endmodule
